// File: rtl/msff_mon_pkg.sv
// Shared types and defaults for the MS flip-flop output monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package msff_mon_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_SET     = 2'b01,
        ST_RST     = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    localparam int CNT_W_DEF     = 8;
    localparam int FAULT_CYC_DEF = 3;
    // Wide enough for the largest legal FAULT_CYC (15).
    localparam int RUN_W         = 4;

    // A latch output pair is meaningful only when Q and Q_L disagree.
    function automatic logic pair_valid(input logic q, input logic ql);
        return q != ql;
    endfunction

endpackage

// File: rtl/msff_monitor_if.sv
// Bundle of flip-flop inputs, clear strobe and monitor results.
// Latency: n/a (wiring only).
// Backpressure: none; the monitor is a pure observer.
interface msff_monitor_if
    import msff_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             Q_IN;
    logic             Q_L_IN;
    logic             CLR_CNT;
    logic             RISE_PULSE;
    logic             FALL_PULSE;
    logic [CNT_W-1:0] SET_CNT;
    logic [CNT_W-1:0] RST_CNT;
    logic [1:0]       STATE;
    logic             FAULT;
    logic             SAT;

    // Stimulus / flip-flop side.
    modport master (
        output Q_IN, Q_L_IN, CLR_CNT,
        input  RISE_PULSE, FALL_PULSE, SET_CNT, RST_CNT, STATE, FAULT, SAT
    );

    // Monitor side.
    modport slave (
        input  Q_IN, Q_L_IN, CLR_CNT,
        output RISE_PULSE, FALL_PULSE, SET_CNT, RST_CNT, STATE, FAULT, SAT
    );
endinterface

// File: rtl/msff_monitor_sync2.sv
// One-bit two-flop synchronizer for a signal from a foreign clock domain.
// Latency: 2 CLK cycles; resets to 0.
// Backpressure: none.
module msff_monitor_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first one a full cycle to resolve.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/msff_monitor.sv
// Classifies a master-slave SR flip-flop's Q/Q_L pair, pulses and counts edges, flags persistent illegal pairs.
// Latency: input to outputs 2 CLK edges (3 with MSFF_MON_SYNC_EN defined, which adds a 2-flop synchronizer).
// Backpressure: none; observes every cycle, CLR_CNT acts on the edge it is sampled.
module msff_monitor
    import msff_mon_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int FAULT_CYC = FAULT_CYC_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    msff_monitor_if.slave mon
);
    localparam logic [RUN_W:0]   FAULT_LIM = (RUN_W+1)'(FAULT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic q_s;
    logic ql_s;

`ifdef MSFF_MON_SYNC_EN
    // The synchronizer's second flop doubles as the sample register.
    msff_monitor_sync2 u_sync_q  (.CLK(CLK), .RST(RST), .d_i(mon.Q_IN),   .q_o(q_s));
    msff_monitor_sync2 u_sync_ql (.CLK(CLK), .RST(RST), .d_i(mon.Q_L_IN), .q_o(ql_s));
`else
    logic q_s_q;
    logic ql_s_q;

    // Single sample register: the flip-flop shares our clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_s_q  <= 1'b0;
            ql_s_q <= 1'b0;
        end else begin
            q_s_q  <= mon.Q_IN;
            ql_s_q <= mon.Q_L_IN;
        end
    end

    assign q_s  = q_s_q;
    assign ql_s = ql_s_q;
`endif

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             fault_q, fault_d;
    logic             sat_q, sat_d;

    logic valid;
    logic run_hit;
    logic rise_ev;
    logic fall_ev;

    assign valid   = pair_valid(q_s, ql_s);
    // This invalid sample completes the run that latches FAULT.
    assign run_hit = ({1'b0, run_q} + 1'b1) >= FAULT_LIM;
    // Only a transition between two held states is an event; UNKNOWN acquisition is not.
    assign rise_ev = (state_q == ST_RST) && valid &&  q_s;
    assign fall_ev = (state_q == ST_SET) && valid && !q_s;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_UNKNOWN;
        else     state_q <= state_d;
    end

    // Next state: valid pairs select the held state, long invalid runs fault, FAULT is absorbing until cleared.
    always_comb begin
        state_d = state_q;
        if (state_q != ST_FAULT) begin
            if (valid)        state_d = q_s ? ST_SET : ST_RST;
            else if (run_hit) state_d = ST_FAULT;
        end
        if (mon.CLR_CNT && state_d == ST_FAULT) state_d = ST_UNKNOWN;
    end

    // Output next values: pulses, saturating counters, run counter; the clear wins on counters but not pulses.
    always_comb begin
        rise_d    = rise_ev;
        fall_d    = fall_ev;
        set_cnt_d = set_cnt_q;
        rst_cnt_d = rst_cnt_q;
        sat_d     = sat_q;
        fault_d   = fault_q || (state_d == ST_FAULT);
        run_d     = run_q;

        if (rise_ev) begin
            if (set_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                      set_cnt_d = set_cnt_q + 1'b1;
        end
        if (fall_ev) begin
            if (rst_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                      rst_cnt_d = rst_cnt_q + 1'b1;
        end

        if (state_q == ST_FAULT || valid || run_hit) run_d = '0;
        else                                         run_d = run_q + 1'b1;

        if (mon.CLR_CNT) begin
            set_cnt_d = '0;
            rst_cnt_d = '0;
            sat_d     = 1'b0;
            fault_d   = 1'b0;
            run_d     = '0;
        end
    end

    // Output and run-counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            set_cnt_q <= '0;
            rst_cnt_q <= '0;
            fault_q   <= 1'b0;
            sat_q     <= 1'b0;
            run_q     <= '0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            set_cnt_q <= set_cnt_d;
            rst_cnt_q <= rst_cnt_d;
            fault_q   <= fault_d;
            sat_q     <= sat_d;
            run_q     <= run_d;
        end
    end

    assign mon.RISE_PULSE = rise_q;
    assign mon.FALL_PULSE = fall_q;
    assign mon.SET_CNT    = set_cnt_q;
    assign mon.RST_CNT    = rst_cnt_q;
    assign mon.STATE      = state_q;
    assign mon.FAULT      = fault_q;
    assign mon.SAT        = sat_q;
endmodule

// File: doc/msff_monitor.md
Name: msff_monitor

Overview:
- Downstream observer for the master-slave SR flip-flop stage; consumes its Q / Q_L pair.
- Samples the pair into the CLK domain and classifies the latch state (set / reset / unknown / fault).
- Emits one-cycle edge pulses and counts set and reset events for the lab display/logging stage.
- Flags persistent illegal output pairs (Q == Q_L), e.g. after the forbidden S=R=1 drive.

Parameters:
CNT_W, 8, width of each event counter
FAULT_CYC, 3, consecutive invalid samples (Q==Q_L) before FAULT latches; legal range 1..15

Ports:
CLK  in  1  system clock, rising-edge active
RST  in  1  asynchronous reset, active-high
Q_IN  in  1  flip-flop Q output
Q_L_IN  in  1  flip-flop Q_L output
CLR_CNT  in  1  synchronous clear of counters, SAT and FAULT
RISE_PULSE  out  1  one-cycle pulse on a valid reset->set transition
FALL_PULSE  out  1  one-cycle pulse on a valid set->reset transition
SET_CNT  out  CNT_W  number of reset->set transitions
RST_CNT  out  CNT_W  number of set->reset transitions
STATE  out  2  00 UNKNOWN, 01 HELD_SET, 10 HELD_RST, 11 FAULT
FAULT  out  1  sticky illegal-pair flag
SAT  out  1  sticky; either counter has saturated

Behaviour:
- Reset (RST=1, asynchronous): all outputs 0, STATE=UNKNOWN, sample registers 0, invalid-run counter 0. Asserting RST between edges forces outputs to 0 immediately. Deassertion takes effect on the next CLK edge.
- Sampling: the pair (q_s, ql_s) is registered once per CLK. This gives 1 cycle of sample latency, or 2 cycles with the optional synchronizer.
- Pair is valid when q_s != ql_s.
- All outputs are registered.
- Valid pair with q_s=1: next state HELD_SET. With q_s=0: next state HELD_RST.
- UNKNOWN -> HELD_SET / HELD_RST: no pulse, no count. This is initial acquisition, not an event.
- HELD_RST -> HELD_SET: RISE_PULSE=1 for exactly one cycle, SET_CNT+1.
- HELD_SET -> HELD_RST: FALL_PULSE=1 for exactly one cycle, RST_CNT+1.
- Invalid pair: increment the invalid-run counter and hold STATE.
  - When the run reaches FAULT_CYC: STATE=FAULT and FAULT=1 on that same edge.
  - Any valid sample before that resets the run counter to 0.
- Short invalid glitch between identical valid states: no event.
- Short invalid glitch between opposite valid states: the normal edge event is generated on the first valid sample.
- FAULT is absorbing: valid pairs do not leave it; pulses and counting are suppressed. Only RST or CLR_CNT exit FAULT (to UNKNOWN).
- Latency (no sync): input change stable before edge n -> STATE / pulse / count update visible after edge n+1. With sync: after edge n+2.
- Counters saturate at 2^CNT_W-1; no wrap.
  - An increment at saturation sets SAT=1.
  - SAT is sticky until RST or CLR_CNT.
- CLR_CNT=1: SET_CNT=0, RST_CNT=0, SAT=0, FAULT=0, run counter 0.
  - If STATE=FAULT it goes to UNKNOWN; otherwise STATE is kept.
- CLR_CNT coincident with an event: the pulse is still emitted, and the clear wins on the counters (both read 0).
- RISE_PULSE and FALL_PULSE are never high together.

Optional Feature:
- Macro MSFF_MON_SYNC_EN.
- Defined: Q_IN and Q_L_IN each pass through a two-flop synchronizer before the sample register. Sample latency is 2 cycles, reset value 0. Required when the flip-flop runs off a different clock.
- Undefined: single sample register only; latency as stated for no-sync.
- State and counter logic are identical in both builds.

Decomposition:
- Package msff_mon_pkg holds:
  - STATE encodings ST_UNKNOWN=2'b00, ST_SET=2'b01, ST_RST=2'b10, ST_FAULT=2'b11.
  - Default CNT_W and FAULT_CYC constants.
  - Run-counter width (4 bits).
- Sub-module sync2: one-bit two-flop synchronizer with CLK and asynchronous RST. It is instantiated twice, only under MSFF_MON_SYNC_EN.

Test Plan (no sync unless noted, FAULT_CYC=3):
1. RST pulsed high mid-cycle with Q_IN=1, Q_L_IN=0 -> outputs immediately 0, STATE=00. After release, STATE=01, SET_CNT=0, no RISE_PULSE.
2. From HELD_SET apply Q=0/Q_L=1, then Q=1/Q_L=0 -> FALL_PULSE one cycle, RST_CNT=1, STATE=10; then RISE_PULSE one cycle, SET_CNT=1, STATE=01.
3. Q=Q_L=1 for 2 samples then Q=1/Q_L=0 -> STATE stays 01, FAULT=0. Q=Q_L=1 for 3 samples -> FAULT=1, STATE=11. Then a valid pair -> still 11. Then CLR_CNT -> STATE=00, FAULT=0.
4. CNT_W=2, 4 reset->set transitions -> SET_CNT=3, SAT=1. Then CLR_CNT -> SET_CNT=0, SAT=0.
5. CLR_CNT asserted on the same edge as a reset->set event -> RISE_PULSE=1, SET_CNT=0.
6. MSFF_MON_SYNC_EN defined, Q toggle stable before edge n -> RISE_PULSE visible after edge n+2, not after n+1.
